// File: rtl/rnn_pkg.sv
// ---------------------------------------------------------------------------
// rnn_pkg
//   Shared types and constants for the RNN sequencer.
//   - seq_state_t : 3-bit sequencer state, also exported to the host as state_o
//   - ADDR_*      : host register addresses decoded by the Avalon front end
//   - state_is_busy(): states in which the sequencer refuses new commands
// ---------------------------------------------------------------------------
package rnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_ACC   = 3'd2,
    S_HUPD  = 3'd3,
    S_DMUL  = 3'd4,
    S_VALID = 3'd5
  } seq_state_t;

  localparam logic [2:0] ADDR_START = 3'd0;
  localparam logic [2:0] ADDR_CHAR  = 3'd1;
  localparam logic [2:0] ADDR_W     = 3'd2;
  localparam logic [2:0] ADDR_R     = 3'd3;
  localparam logic [2:0] ADDR_B     = 3'd4;
  localparam logic [2:0] ADDR_DV    = 3'd5;
  localparam logic [2:0] ADDR_DB    = 3'd6;
  localparam logic [2:0] ADDR_DENSE = 3'd7;

  // Only IDLE and VALID accept host commands.
  function automatic logic state_is_busy(input seq_state_t s);
    return !((s == S_IDLE) || (s == S_VALID));
  endfunction

endpackage

// File: rtl/rnn_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// rnn_seq_ctrl_if
//   Bundles the sequencer's command, unit handshake and status signals.
//   Modports:
//     slave  : the sequencer (consumes commands and done pulses, drives
//              start pulses, strobes and status)
//     master : host front end and matrix units (the other side)
//   Signals:
//     cmd_step/cmd_dense/cmd_clear : 1-cycle host command pulses
//     wm_start/rm_start/dn_start   : 1-cycle unit start pulses
//     wm_done/rm_done/dn_done      : 1-cycle unit done pulses
//     acc_en/hidden_we/hidden_clr  : 1-cycle datapath strobes
//     busy/valid/err               : status (err is sticky)
//     step_cnt                     : completed timesteps (STEP_W bits)
//     state_o                      : current sequencer state
// ---------------------------------------------------------------------------
interface rnn_seq_ctrl_if #(
  parameter int STEP_W = 8
);
  import rnn_pkg::*;

  logic              cmd_step;
  logic              cmd_dense;
  logic              cmd_clear;
  logic              wm_start;
  logic              rm_start;
  logic              wm_done;
  logic              rm_done;
  logic              acc_en;
  logic              hidden_we;
  logic              hidden_clr;
  logic              dn_start;
  logic              dn_done;
  logic              busy;
  logic              valid;
  logic              err;
  logic [STEP_W-1:0] step_cnt;
  seq_state_t        state_o;

  modport slave (
    input  cmd_step, cmd_dense, cmd_clear, wm_done, rm_done, dn_done,
    output wm_start, rm_start, acc_en, hidden_we, hidden_clr, dn_start,
           busy, valid, err, step_cnt, state_o
  );

  modport master (
    output cmd_step, cmd_dense, cmd_clear, wm_done, rm_done, dn_done,
    input  wm_start, rm_start, acc_en, hidden_we, hidden_clr, dn_start,
           busy, valid, err, step_cnt, state_o
  );

endinterface

// File: rtl/rnn_watchdog.sv
// ---------------------------------------------------------------------------
// rnn_watchdog
//   Cycle counter that flags expiry after TIMEOUT enabled cycles.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_clr      : synchronous clear of the count (wins over i_en)
//     i_en       : count this cycle
//     o_expire   : high in the TIMEOUT-th enabled cycle since the last clear
//   TIMEOUT = 0 disables the watchdog (o_expire tied low).
// ---------------------------------------------------------------------------
module rnn_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  generate
    if (TIMEOUT > 0) begin : g_on
      logic [TO_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // Count starts at 0 in the first enabled cycle, so TIMEOUT-1 marks
      // the last cycle the owner is allowed to wait.
      assign o_expire = i_en && (r_cnt == TO_W'(TIMEOUT - 1));
    end else begin : g_off
      logic w_unused_ok;
      assign w_unused_ok = &{1'b0, clk, rst_n, i_clr, i_en};
      assign o_expire    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rnn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rnn_seq_ctrl
//   Sequencer for one RNN timestep (W*x and R*h in parallel, accumulate,
//   hidden update) and for the final dense stage.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset; aborts any operation at once
//     bus   : rnn_seq_ctrl_if.slave (commands, unit handshakes, strobes,
//             busy/valid/err status, step_cnt, state_o)
//   Parameters:
//     STEP_W  : step counter width (saturating)
//     TIMEOUT : max cycles in MUL/DMUL before abort; 0 disables
// ---------------------------------------------------------------------------
module rnn_seq_ctrl
  import rnn_pkg::*;
#(
  parameter  int STEP_W  = 8,
  parameter  int TIMEOUT = 1024,
  localparam int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rnn_seq_ctrl_if.slave  bus
);

  seq_state_t        r_state;
  logic              r_w_ok;
  logic              r_r_ok;
  logic [STEP_W-1:0] r_step_cnt;
  logic              r_wm_start;
  logic              r_rm_start;
  logic              r_acc_en;
  logic              r_hidden_we;
  logic              r_hidden_clr;
  logic              r_dn_start;
  logic              r_busy;
  logic              r_valid;
  logic              r_err;

  logic w_any_cmd;
  logic w_wd_en;
  logic w_wd_expire;
  logic w_w_ok_next;
  logic w_r_ok_next;
  logic w_dn_hit;

  assign w_any_cmd = bus.cmd_step | bus.cmd_dense | bus.cmd_clear;
  assign w_wd_en   = (r_state == S_MUL) || (r_state == S_DMUL);

  // The start registers are high exactly in the first MUL/DMUL cycle, so
  // they double as the "ignore done in the start cycle" qualifier.
  assign w_w_ok_next = r_w_ok | (bus.wm_done & ~r_wm_start);
  assign w_r_ok_next = r_r_ok | (bus.rm_done & ~r_rm_start);
  assign w_dn_hit    = bus.dn_done & ~r_dn_start;

  rnn_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (~w_wd_en),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_w_ok       <= 1'b0;
      r_r_ok       <= 1'b0;
      r_step_cnt   <= '0;
      r_wm_start   <= 1'b0;
      r_rm_start   <= 1'b0;
      r_acc_en     <= 1'b0;
      r_hidden_we  <= 1'b0;
      r_hidden_clr <= 1'b0;
      r_dn_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // All strobes are single-cycle; they are only raised below.
      r_wm_start   <= 1'b0;
      r_rm_start   <= 1'b0;
      r_acc_en     <= 1'b0;
      r_hidden_we  <= 1'b0;
      r_hidden_clr <= 1'b0;
      r_dn_start   <= 1'b0;

      // Commands arriving while busy are dropped and flagged.
      if (state_is_busy(r_state) && w_any_cmd) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE, S_VALID: begin
          if (bus.cmd_clear) begin
            // Clear resets err, but a step/dense dropped in the same cycle
            // must still be reported.
            r_hidden_clr <= 1'b1;
            r_step_cnt   <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= bus.cmd_step | bus.cmd_dense;
            r_state      <= S_IDLE;
          end else if (bus.cmd_step) begin
            r_wm_start <= 1'b1;
            r_rm_start <= 1'b1;
            r_valid    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MUL;
            if (bus.cmd_dense) begin
              r_err <= 1'b1;
            end
          end else if (bus.cmd_dense) begin
            r_dn_start <= 1'b1;
            r_valid    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_DMUL;
          end
        end

        S_MUL: begin
          // Completion takes precedence over a simultaneous expiry.
          if (w_w_ok_next && w_r_ok_next) begin
            r_w_ok   <= 1'b0;
            r_r_ok   <= 1'b0;
            r_acc_en <= 1'b1;
            r_state  <= S_ACC;
          end else if (w_wd_expire) begin
            r_w_ok  <= 1'b0;
            r_r_ok  <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_w_ok <= w_w_ok_next;
            r_r_ok <= w_r_ok_next;
          end
        end

        S_ACC: begin
          r_hidden_we <= 1'b1;
          r_state     <= S_HUPD;
        end

        S_HUPD: begin
          if (r_step_cnt != {STEP_W{1'b1}}) begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        S_DMUL: begin
          if (w_dn_hit) begin
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_VALID;
          end else if (w_wd_expire) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_w_ok  <= 1'b0;
          r_r_ok  <= 1'b0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wm_start   = r_wm_start;
  assign bus.rm_start   = r_rm_start;
  assign bus.acc_en     = r_acc_en;
  assign bus.hidden_we  = r_hidden_we;
  assign bus.hidden_clr = r_hidden_clr;
  assign bus.dn_start   = r_dn_start;
  assign bus.busy       = r_busy;
  assign bus.valid      = r_valid;
  assign bus.err        = r_err;
  assign bus.step_cnt   = r_step_cnt;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rnn_seq_ctrl
//   Directed bench for rnn_seq_ctrl (TIMEOUT=16, STEP_W=8). Inputs change
//   1 time unit after the rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_rnn_seq_ctrl;
  import rnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rnn_seq_ctrl_if #(.STEP_W(8)) bus ();

  rnn_seq_ctrl #(
    .STEP_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters sampled mid-cycle.
  int n_wm = 0, n_rm = 0, n_acc = 0, n_hwe = 0, n_hclr = 0, n_dn = 0;
  always @(negedge clk) begin
    if (bus.wm_start   === 1'b1) n_wm++;
    if (bus.rm_start   === 1'b1) n_rm++;
    if (bus.acc_en     === 1'b1) n_acc++;
    if (bus.hidden_we  === 1'b1) n_hwe++;
    if (bus.hidden_clr === 1'b1) n_hclr++;
    if (bus.dn_start   === 1'b1) n_dn++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int a0, h0, w0, r0, d0, c0, held;

    rst_n         = 1'b0;
    bus.cmd_step  = 1'b0;
    bus.cmd_dense = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.wm_done   = 1'b0;
    bus.rm_done   = 1'b0;
    bus.dn_done   = 1'b0;

    // ---- reset state
    repeat (3) tick();
    chk("rst_state", bus.state_o, S_IDLE);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_step_cnt", bus.step_cnt, 0);
    chk("rst_strobes", {bus.wm_start, bus.rm_start, bus.acc_en, bus.hidden_we,
                        bus.hidden_clr, bus.dn_start}, 0);
    rst_n = 1'b1;
    tick();

    // ---- test 1: step, wm_done@+3, rm_done@+5
    $display("txn: step, wm_done@+3, rm_done@+5");
    a0 = n_acc; h0 = n_hwe; w0 = n_wm; r0 = n_rm;
    bus.cmd_step = 1'b1;
    tick();                                  // T+1
    bus.cmd_step = 1'b0;
    chk("t1_wm_start", bus.wm_start, 1);
    chk("t1_rm_start", bus.rm_start, 1);
    chk("t1_state_mul", bus.state_o, S_MUL);
    chk("t1_busy", bus.busy, 1);
    tick();                                  // T+2
    chk("t1_start_oneshot", bus.wm_start, 0);
    tick();                                  // T+3
    bus.wm_done = 1'b1;
    tick();                                  // T+4
    bus.wm_done = 1'b0;
    tick();                                  // T+5
    bus.rm_done = 1'b1;
    chk("t1_no_early_acc", bus.acc_en, 0);
    tick();                                  // T+6
    bus.rm_done = 1'b0;
    chk("t1_acc_en", bus.acc_en, 1);
    chk("t1_state_acc", bus.state_o, S_ACC);
    tick();                                  // T+7
    chk("t1_hidden_we", bus.hidden_we, 1);
    chk("t1_acc_oneshot", bus.acc_en, 0);
    tick();                                  // T+8
    chk("t1_busy_low", bus.busy, 0);
    chk("t1_state_idle", bus.state_o, S_IDLE);
    chk("t1_step_cnt", bus.step_cnt, 1);
    chk("t1_err", bus.err, 0);
    chk("t1_acc_count", n_acc - a0, 1);
    chk("t1_hwe_count", n_hwe - h0, 1);
    chk("t1_wm_count", n_wm - w0, 1);
    chk("t1_rm_count", n_rm - r0, 1);

    // ---- test 2: second step; dones in the start cycle are ignored, then
    //      both dones in the same cycle
    $display("txn: step, dones in start cycle then both @+2");
    a0 = n_acc; h0 = n_hwe;
    bus.cmd_step = 1'b1;
    tick();                                  // T+1 (start cycle)
    bus.cmd_step = 1'b0;
    bus.wm_done  = 1'b1;
    bus.rm_done  = 1'b1;
    tick();                                  // T+2
    chk("t2_start_done_ignored", bus.state_o, S_MUL);
    chk("t2_no_acc", bus.acc_en, 0);
    tick();                                  // T+3
    bus.wm_done = 1'b0;
    bus.rm_done = 1'b0;
    chk("t2_acc_en", bus.acc_en, 1);
    tick();                                  // T+4
    chk("t2_hidden_we", bus.hidden_we, 1);
    tick();                                  // T+5
    chk("t2_state_idle", bus.state_o, S_IDLE);
    chk("t2_step_cnt", bus.step_cnt, 2);
    chk("t2_acc_count", n_acc - a0, 1);
    chk("t2_hwe_count", n_hwe - h0, 1);
    chk("t2_err", bus.err, 0);

    // ---- test 3: dn_done while IDLE, then cmd_step during MUL
    $display("txn: dn_done in IDLE");
    bus.dn_done = 1'b1;
    tick();
    bus.dn_done = 1'b0;
    chk("t3_idle_dn_state", bus.state_o, S_IDLE);
    chk("t3_idle_dn_valid", bus.valid, 0);
    chk("t3_idle_dn_err", bus.err, 0);
    tick();
    $display("txn: step, extra cmd_step during MUL");
    w0 = n_wm;
    bus.cmd_step = 1'b1;
    tick();                                  // T+1
    bus.cmd_step = 1'b0;
    tick();                                  // T+2
    bus.cmd_step = 1'b1;
    tick();                                  // T+3
    bus.cmd_step = 1'b0;
    chk("t3_err", bus.err, 1);
    chk("t3_state_mul", bus.state_o, S_MUL);
    chk("t3_no_restart", bus.wm_start, 0);
    bus.wm_done = 1'b1;
    bus.rm_done = 1'b1;
    tick();                                  // T+4
    bus.wm_done = 1'b0;
    bus.rm_done = 1'b0;
    chk("t3_acc_en", bus.acc_en, 1);
    tick();
    tick();                                  // T+6
    chk("t3_step_cnt", bus.step_cnt, 3);
    chk("t3_wm_count", n_wm - w0, 1);
    chk("t3_err_sticky", bus.err, 1);

    $display("txn: clear");
    c0 = n_hclr;
    bus.cmd_clear = 1'b1;
    tick();
    bus.cmd_clear = 1'b0;
    chk("clr_hidden_clr", bus.hidden_clr, 1);
    chk("clr_step_cnt", bus.step_cnt, 0);
    chk("clr_err", bus.err, 0);
    chk("clr_state", bus.state_o, S_IDLE);
    tick();
    chk("clr_oneshot", n_hclr - c0, 1);

    // ---- test 4: dense, dn_done@+4, valid held, next step drops valid
    $display("txn: dense, dn_done@+4");
    d0 = n_dn;
    bus.cmd_dense = 1'b1;
    tick();                                  // T+1
    bus.cmd_dense = 1'b0;
    chk("t4_dn_start", bus.dn_start, 1);
    chk("t4_state_dmul", bus.state_o, S_DMUL);
    chk("t4_busy", bus.busy, 1);
    tick();                                  // T+2
    tick();                                  // T+3
    tick();                                  // T+4
    bus.dn_done = 1'b1;
    tick();                                  // T+5
    bus.dn_done = 1'b0;
    chk("t4_valid", bus.valid, 1);
    chk("t4_state_valid", bus.state_o, S_VALID);
    chk("t4_busy_low", bus.busy, 0);
    held = 0;
    repeat (20) begin
      tick();
      if (bus.valid === 1'b1 && bus.state_o === S_VALID) held++;
    end
    chk("t4_valid_held", held, 20);
    chk("t4_dn_count", n_dn - d0, 1);
    $display("txn: step from VALID");
    bus.cmd_step = 1'b1;
    tick();                                  // T+1
    bus.cmd_step = 1'b0;
    chk("t4_valid_dropped", bus.valid, 0);
    chk("t4_step_state", bus.state_o, S_MUL);
    chk("t4_step_start", bus.wm_start, 1);
    tick();                                  // T+2
    bus.wm_done = 1'b1;
    bus.rm_done = 1'b1;
    tick();                                  // T+3
    bus.wm_done = 1'b0;
    bus.rm_done = 1'b0;
    tick();
    tick();                                  // T+5
    chk("t4_step_cnt", bus.step_cnt, 1);
    chk("t4_err", bus.err, 0);

    // ---- test 5: watchdog, rm_done never arrives
    $display("txn: step, rm_done missing (timeout 16)");
    a0 = n_acc; h0 = n_hwe;
    bus.cmd_step = 1'b1;
    tick();                                  // T+1
    bus.cmd_step = 1'b0;
    tick();                                  // T+2
    tick();                                  // T+3
    bus.wm_done = 1'b1;
    tick();                                  // T+4
    bus.wm_done = 1'b0;
    repeat (12) tick();                      // T+16
    chk("t5_still_mul", bus.state_o, S_MUL);
    chk("t5_no_err_yet", bus.err, 0);
    tick();                                  // T+17
    chk("t5_state_idle", bus.state_o, S_IDLE);
    chk("t5_err", bus.err, 1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_step_cnt", bus.step_cnt, 1);
    chk("t5_no_acc", n_acc - a0, 0);
    chk("t5_no_hwe", n_hwe - h0, 0);

    // ---- test 6: reset mid-MUL, then clear+step together
    $display("txn: step, reset mid-MUL");
    bus.cmd_step = 1'b1;
    tick();                                  // T+1
    bus.cmd_step = 1'b0;
    chk("t6_started", bus.wm_start, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wm_start", bus.wm_start, 0);
    chk("t6_rst_state", bus.state_o, S_IDLE);
    chk("t6_rst_err", bus.err, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_step_cnt", bus.step_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("txn: clear + step same cycle");
    bus.cmd_clear = 1'b1;
    bus.cmd_step  = 1'b1;
    tick();
    bus.cmd_clear = 1'b0;
    bus.cmd_step  = 1'b0;
    chk("t6_hidden_clr", bus.hidden_clr, 1);
    chk("t6_err_dropped", bus.err, 1);
    chk("t6_state_idle", bus.state_o, S_IDLE);
    chk("t6_no_start", bus.wm_start, 0);
    chk("t6_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
